mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter_pkg.sv | 28 ++
 rtl/mode_counter_timer.sv | 56 +++++
 rtl/mode_counter.sv | 165 ++++++++++++++++
 tb/tb_mode_counter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mode_counter_pkg
// Description : Shared types and constants for the mode counter: the state
//               encoding, the state enum and the default auto-repeat hold
//               length.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mode_counter_pkg;

  localparam logic [1:0] c_state_idle  = 2'd0;
  localparam logic [1:0] c_state_run   = 2'd1;
  localparam logic [1:0] c_state_pause = 2'd2;
  localparam logic [1:0] c_state_step  = 2'd3;

  // One auto-repeat step per second on a 150 MHz board clock.
  localparam int unsigned c_default_hold_cycles = 150_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = c_state_idle,
    ST_RUN   = c_state_run,
    ST_PAUSE = c_state_pause,
    ST_STEP  = c_state_step
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mode_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : mode_counter_timer
// Description : Terminal-count timer. Counts enabled cycles and pulses done_o
//               combinationally in the cycle the TERMINAL-th enabled cycle is
//               seen, then restarts from zero.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous active-high reset
//               clear_i - restart the count from zero (wins over en_i)
//               en_i    - count this cycle
//               done_o  - terminal count reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mode_counter_timer #(
  parameter int unsigned TERMINAL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned c_cnt_w = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TERMINAL - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  // done_o is kept independent of clear_i so that the parent may derive the
  // clear from its own next-state logic without forming a loop.
  assign done_o = en_i && (cnt_q == c_last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == c_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
// Module      : mode_counter
// Description : Up/down counter with free-running (RUN), paused, idle and
//               button auto-repeat (STEP) modes. Limits either wrap or
//               saturate; every step raises tick_o, steps at a limit also
//               raise limit_o.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous active-high reset
//               run_i   - pulse: start free-running count
//               step_i  - debounced button level, held for auto-repeat
//               stop_i  - pulse: pause
//               clear_i - pulse: zero count, back to IDLE
//               up_i    - direction, 1 = +1, 0 = -1
//               count_o - current count (registered)
//               state_o - current state encoding (registered)
//               tick_o  - count_o shows a new step result this cycle
//               limit_o - that step hit a limit (wrap or saturate)
// Revision    : 1.0 - initial release
// ============================================================================
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned MAX_COUNT   = (1 << WIDTH) - 1,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned HOLD_CYCLES = c_default_hold_cycles,
  parameter int unsigned WRAP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             tick_o,
  output logic             limit_o
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             limit_q, limit_d;

  logic pre_en, pre_clr, pre_done;
  logic hold_en, hold_clr, hold_done;
  logic do_step;

  // Both timers restart whenever the state changes, so every entry into RUN
  // or STEP begins with a full prescale / hold interval.
  assign pre_en   = (state_q == ST_RUN);
  assign pre_clr  = clear_i || (state_d != state_q);
  assign hold_en  = (state_q == ST_STEP) && step_i;
  assign hold_clr = clear_i || (state_d != state_q) || !step_i;

  mode_counter_timer #(
    .TERMINAL (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear_i (pre_clr),
    .en_i    (pre_en),
    .done_o  (pre_done)
  );

  mode_counter_timer #(
    .TERMINAL (HOLD_CYCLES)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .clear_i (hold_clr),
    .en_i    (hold_en),
    .done_o  (hold_done)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    limit_d = 1'b0;
    do_step = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (run_i) begin
          state_d = ST_RUN;
        end else if (step_i) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (pre_done) begin
          do_step = 1'b1;
        end
      end
      ST_STEP: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (run_i) begin
          state_d = ST_RUN;
        end else if (hold_done) begin
          do_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Limits are compared explicitly; the adder never relies on overflow.
    if (do_step) begin
      tick_d = 1'b1;
      if (up_i) begin
        if (count_q == c_max) begin
          limit_d = 1'b1;
          count_d = (WRAP != 0) ? c_zero : c_max;
        end else begin
          count_d = count_q + c_one;
        end
      end else begin
        if (count_q == c_zero) begin
          limit_d = 1'b1;
          count_d = (WRAP != 0) ? c_max : c_zero;
        end else begin
          count_d = count_q - c_one;
        end
      end
    end

    if (clear_i) begin
      state_d = ST_IDLE;
      count_d = c_zero;
      tick_d  = 1'b0;
      limit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      limit_q <= limit_d;
    end
  end

  assign count_o = count_q;
  assign state_o = state_q;
  assign tick_o  = tick_q;
  assign limit_o = limit_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_counter
// Description : Scoreboard bench for mode_counter. Two instances (wrapping
//               and saturating) share stimulus; a behavioural model queues
//               the expected state/count per cycle and the expected step
//               events, and a monitor compares them against the outputs.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_counter;

  localparam int W    = 4;
  localparam int MAXC = 9;
  localparam int PRE  = 3;
  localparam int HOLD = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         run_i = 1'b0;
  logic         step_i = 1'b0;
  logic         stop_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         up_i = 1'b1;
  logic [W-1:0] count_w, count_s;
  logic [1:0]   state_w, state_s;
  logic         tick_w, tick_s, limit_w, limit_s;

  always #5 clk = ~clk;

  mode_counter #(
    .WIDTH (W), .MAX_COUNT (MAXC), .PRESCALE (PRE), .HOLD_CYCLES (HOLD), .WRAP (1)
  ) u_dut_wrap (
    .clk (clk), .reset (reset), .run_i (run_i), .step_i (step_i),
    .stop_i (stop_i), .clear_i (clear_i), .up_i (up_i),
    .count_o (count_w), .state_o (state_w), .tick_o (tick_w), .limit_o (limit_w)
  );

  mode_counter #(
    .WIDTH (W), .MAX_COUNT (MAXC), .PRESCALE (PRE), .HOLD_CYCLES (HOLD), .WRAP (0)
  ) u_dut_sat (
    .clk (clk), .reset (reset), .run_i (run_i), .step_i (step_i),
    .stop_i (stop_i), .clear_i (clear_i), .up_i (up_i),
    .count_o (count_s), .state_o (state_s), .tick_o (tick_s), .limit_o (limit_s)
  );

  typedef struct { int cyc; int state; int cnt_w; int cnt_s; } stat_t;
  typedef struct { int cyc; bit lim_w; bit lim_s; } step_ev_t;

  stat_t    stat_q[$];
  step_ev_t step_q[$];
  int       n_checks = 0;
  int       n_errors = 0;
  bit       mon_en = 1'b0;

  // Reference model: state 0 idle, 1 run, 2 pause, 3 step.
  int m_state = 0, m_cw = 0, m_cs = 0, m_pre = 0, m_hold = 0, m_cyc = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Step result from plain arithmetic on the unbounded value.
  function automatic void apply_step(input int c, input bit up, input bit wrap,
                                     output int nc, output bit lim);
    int raw;
    raw = up ? c + 1 : c - 1;
    lim = (raw > MAXC) || (raw < 0);
    if (wrap) nc = (raw + MAXC + 1) % (MAXC + 1);
    else      nc = (raw > MAXC) ? MAXC : ((raw < 0) ? 0 : raw);
  endfunction

  task automatic model_cycle();
    bit       stepping;
    step_ev_t ev;
    stat_t    st;
    stepping = 1'b0;
    if (reset || clear_i) begin
      m_state = 0; m_cw = 0; m_cs = 0; m_pre = 0; m_hold = 0;
    end else begin
      case (m_state)
        0, 2: begin
          if (run_i)       begin m_state = 1; m_pre = 0; end
          else if (step_i) begin m_state = 3; m_hold = 0; end
        end
        1: begin
          if (stop_i) m_state = 2;
          else begin
            m_pre++;
            if (m_pre == PRE) begin m_pre = 0; stepping = 1'b1; end
          end
        end
        default: begin
          if (stop_i)     m_state = 2;
          else if (run_i) begin m_state = 1; m_pre = 0; end
          else if (step_i) begin
            m_hold++;
            if (m_hold == HOLD) begin m_hold = 0; stepping = 1'b1; end
          end else m_hold = 0;
        end
      endcase
    end
    if (stepping) begin
      ev.cyc = m_cyc;
      apply_step(m_cw, up_i, 1'b1, m_cw, ev.lim_w);
      apply_step(m_cs, up_i, 1'b0, m_cs, ev.lim_s);
      step_q.push_back(ev);
    end
    st.cyc = m_cyc; st.state = m_state; st.cnt_w = m_cw; st.cnt_s = m_cs;
    stat_q.push_back(st);
    m_cyc++;
  endtask

  // Inputs are applied #1 after a rising edge; the model predicts the
  // outputs the next edge will produce.
  task automatic cycle();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  always @(negedge clk) begin
    stat_t    s;
    step_ev_t e;
    if (mon_en) begin
      if (stat_q.size() == 0) begin
        chk("stat_queue_underflow", 0, 1);
      end else begin
        s = stat_q.pop_front();
        chk("state_o_wrap", int'(state_w), s.state);
        chk("state_o_sat",  int'(state_s), s.state);
        chk("count_o_wrap", int'(count_w), s.cnt_w);
        chk("count_o_sat",  int'(count_s), s.cnt_s);
        if (step_q.size() > 0 && step_q[0].cyc == s.cyc) begin
          e = step_q.pop_front();
          chk("tick_o_wrap",  int'(tick_w),  1);
          chk("tick_o_sat",   int'(tick_s),  1);
          chk("limit_o_wrap", int'(limit_w), int'(e.lim_w));
          chk("limit_o_sat",  int'(limit_s), int'(e.lim_s));
        end else begin
          chk("tick_o_wrap_quiet",  int'(tick_w),  0);
          chk("tick_o_sat_quiet",   int'(tick_s),  0);
          chk("limit_o_wrap_quiet", int'(limit_w), 0);
          chk("limit_o_sat_quiet",  int'(limit_s), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mon_en = 1'b1;

    // Reset overrides active inputs.
    reset = 1'b1; run_i = 1'b1; step_i = 1'b1;
    idle(2);
    reset = 1'b0; run_i = 1'b0; step_i = 1'b0;
    chk("reset_state", int'(state_w), 0);
    chk("reset_count", int'(count_w), 0);
    chk("reset_tick",  int'(tick_w),  0);

    // RUN: first step PRESCALE edges after entry, then every PRESCALE.
    run_i = 1'b1; cycle(); run_i = 1'b0;
    chk("run_entry_state", int'(state_w), 1);
    idle(2);
    chk("run_before_first_step", int'(count_w), 0);
    idle(1);
    chk("run_first_step", int'(count_w), 1);
    chk("run_first_tick", int'(tick_w), 1);
    idle(6);
    chk("run_third_step", int'(count_w), 3);

    // Up to the top, then one step past it.
    idle(18);
    chk("run_at_max", int'(count_w), 9);
    idle(3);
    chk("wrap_up_count", int'(count_w), 0);
    chk("sat_up_count",  int'(count_s), 9);
    chk("wrap_up_limit", int'(limit_w), 1);
    chk("sat_up_limit",  int'(limit_s), 1);

    // stop_i beats run_i; clear_i zeroes without a tick.
    idle(15);
    chk("run_count5", int'(count_w), 5);
    stop_i = 1'b1; run_i = 1'b1; cycle(); stop_i = 1'b0; run_i = 1'b0;
    chk("pause_state", int'(state_w), 2);
    idle(6);
    chk("pause_hold_count", int'(count_w), 5);
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    chk("clear_state", int'(state_w), 0);
    chk("clear_count", int'(count_w), 0);
    chk("clear_no_tick", int'(tick_w), 0);

    // Auto-repeat: 12 cycles held gives exactly two steps.
    step_i = 1'b1; idle(12); step_i = 1'b0; idle(8);
    chk("step_state", int'(state_w), 3);
    chk("step_count", int'(count_w), 2);
    stop_i = 1'b1; cycle(); stop_i = 1'b0;

    // Down step from zero.
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    up_i = 1'b0; run_i = 1'b1; cycle(); run_i = 1'b0;
    idle(3);
    chk("wrap_down_count", int'(count_w), 9);
    chk("sat_down_count",  int'(count_s), 0);
    chk("wrap_down_limit", int'(limit_w), 1);
    up_i = 1'b1;

    // Reset mid-RUN discards prescaler progress.
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    run_i = 1'b1; cycle(); run_i = 1'b0;
    idle(17);
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("midrun_reset_state", int'(state_w), 0);
    chk("midrun_reset_count", int'(count_w), 0);
    run_i = 1'b1; cycle(); run_i = 1'b0;
    idle(2);
    chk("after_reset_no_early_step", int'(count_w), 0);
    idle(1);
    chk("after_reset_first_step", int'(count_w), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(399) == 0);
      clear_i = ($urandom_range(149) == 0);
      stop_i  = ($urandom_range(39) == 0);
      run_i   = ($urandom_range(29) == 0);
      if ($urandom_range(7) == 0)  step_i = ~step_i;
      if ($urandom_range(19) == 0) up_i = ~up_i;
      cycle();
    end
    reset = 1'b0; clear_i = 1'b0; stop_i = 1'b0; run_i = 1'b0; step_i = 1'b0;
    idle(4);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("step_queue_drained", step_q.size(), 0);
    chk("stat_queue_drained", stat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
